alu_adder_serial: RTL and testbench
===================================

Name: alu_adder_serial

Overview:
- Multi-cycle add/subtract unit that is the consumer side of the 4-bit adder-half interface.
- Reuses one 4-bit full_adder datapath (full_adder #(.N(4))) once per nibble, LSB nibble first.
- Registers each nibble's carry_out and feeds it back as the next nibble's carry_in.
- Sits between the instruction sequencer (operand handshake) and writeback (result handshake); replaces wide parallel adders where area matters.

Parameters:
- WIDTH, 8, operand/result width in bits; must be a multiple of 4 and at least 4.
- NIBBLES, WIDTH/4, derived localparam; not overridable.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- start_valid  input  1  operands and op valid
- start_ready  output  1  unit can accept an operation
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- subtract  input  1  0 = A+B+carry_in; 1 = A-B-borrow (carry_in is borrow)
- carry_in  input  1  carry in (add) or borrow in (subtract)
- result_valid  output  1  result and flags valid
- result_ready  input  1  downstream accepts result
- result  output  WIDTH  sum/difference
- carry_out  output  1  final carry (add) or borrow (subtract)
- zero  output  1  result == 0
- overflow  output  1  signed two's-complement overflow

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset values: result_valid=0, result=0, carry_out=0, zero=0, overflow=0, state=IDLE, so start_ready=1 after reset releases.
- States: IDLE, RUN, DONE. start_ready=1 only in IDLE; result_valid=1 only in DONE.
- IDLE, start_valid=1, at the clock edge:
  - latch a, subtract.
  - latch b' = b XOR {WIDTH{subtract}}.
  - set carry register c = carry_in XOR subtract.
  - nibble index = 0; go to RUN.
- RUN, each cycle:
  - Adder inputs: nibble[idx] of a, nibble[idx] of b', and c.
  - Write the 4-bit sum into result nibble[idx]; c <= adder carry_out; idx++.
  - On the last nibble (idx = NIBBLES-1), capture the carry into the MSB position for the overflow computation; next state is DONE.
  - RUN lasts exactly NIBBLES cycles.
- Latency: result_valid rises exactly NIBBLES cycles after the accepting edge (8-bit: 2 cycles; 16-bit: 4 cycles).
- Flags are computed when entering DONE:
  - carry_out = final c XOR subtract, so subtract reports a borrow and chained subtracts feed carry_out to carry_in.
  - zero = (result == 0).
  - overflow = carry into MSB XOR carry out of MSB, equivalently (a[MSB]==b'[MSB]) && (result[MSB]!=a[MSB]).
- DONE: result, carry_out, zero and overflow are held stable while result_valid=1.
  - On result_ready=1, go to IDLE; result_valid deasserts next cycle.
  - Outputs keep their values in IDLE until the next DONE.
- Back-to-back operation:
  - start_valid is ignored in RUN and DONE.
  - A new operation cannot be accepted in the same cycle a result is consumed; minimum initiation interval is NIBBLES+2 cycles.
- Operand isolation: a, b, subtract and carry_in are sampled only at the accepting edge; later changes have no effect.
- Reset mid-operation (RUN or DONE): the operation is discarded, all outputs return to reset values immediately, and the state is IDLE.
- Wrap-around: result is modulo 2^WIDTH; no saturation.

Test Plan:
- WIDTH=8, add a=0x3C b=0x47 carry_in=0 -> result=0x83, carry_out=0, overflow=1, zero=0; result_valid high exactly 2 cycles after accept.
- WIDTH=8, add 0xFF+0x01 carry_in=0 -> result=0x00, carry_out=1, zero=1, overflow=0. Add 0x7F+0x00 carry_in=1 -> 0x80, overflow=1.
- WIDTH=8, subtract:
  - 0x10-0x01 borrow=0 -> 0x0F, carry_out=0, overflow=0.
  - 0x00-0x01 -> 0xFF, carry_out=1.
  - 0x80-0x01 -> 0x7F, overflow=1.
  - 0x05-0x04 borrow=1 -> 0x00, zero=1.
- Backpressure: hold result_ready=0 for 5 cycles while toggling a/b/start_valid -> result_valid stays 1, outputs unchanged, start_ready=0. Assert result_ready -> IDLE next cycle, start_ready=1.
- Reset asserted mid-RUN (after the first nibble of 0x3C+0x47) -> result=0, flags=0, result_valid=0 asynchronously. After release, start_ready=1 and a new 0x01+0x01 completes with result=0x02.
- WIDTH=16: 0x0FFF+0x0001 -> 0x1000 with 4-cycle latency. 0x8000-0x0001 -> 0x7FFF, overflow=1, carry_out=0.

Source files
------------

// File: rtl/alu_adder_serial.sv
// Nibble-serial add/subtract unit: one shared 4-bit adder walks the operands
// LSB nibble first, with a registered carry between nibbles.

module full_adder #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
endmodule

module alu_adder_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             subtract,
  input  logic             carry_in,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             zero,
  output logic             overflow
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int IW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;

  logic [WIDTH-1:0] a_q, bx_q, acc, acc_nxt;
  logic             sub_q, c;
  logic [IW-1:0]    idx;
  logic [3:0]       na, nb, nsum;
  logic             fa_cout, last, c_msb, ovf;

  always_comb begin
    na      = '0;
    nb      = '0;
    acc_nxt = acc;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx == IW'(i)) begin
        na = a_q[i*4 +: 4];
        nb = bx_q[i*4 +: 4];
        acc_nxt[i*4 +: 4] = nsum;
      end
    end
  end

  full_adder #(.N(4)) u_fa (
    .a   (na),
    .b   (nb),
    .cin (c),
    .sum (nsum),
    .cout(fa_cout)
  );

  assign last  = (idx == IW'(NIBBLES - 1));
  // Carry into the MSB recovered from the MSB sum bit and its operand bits.
  assign c_msb = a_q[WIDTH-1] ^ bx_q[WIDTH-1] ^ nsum[3];
  assign ovf   = c_msb ^ fa_cout;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_valid)  state_nxt = RUN;
      RUN:     if (last)         state_nxt = DONE;
      DONE:    if (result_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign start_ready  = (state == IDLE);
  assign result_valid = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      a_q       <= '0;
      bx_q      <= '0;
      acc       <= '0;
      sub_q     <= 1'b0;
      c         <= 1'b0;
      idx       <= '0;
      result    <= '0;
      carry_out <= 1'b0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (start_valid) begin
          a_q   <= a;
          bx_q  <= b ^ {WIDTH{subtract}};
          sub_q <= subtract;
          c     <= carry_in ^ subtract;
          idx   <= '0;
        end
        RUN: begin
          acc <= acc_nxt;
          c   <= fa_cout;
          idx <= idx + 1'b1;
          // Output registers only change on entry to DONE.
          if (last) begin
            result    <= acc_nxt;
            zero      <= (acc_nxt == '0);
            carry_out <= fa_cout ^ sub_q;
            overflow  <= ovf;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_adder_serial.sv
// Randomized + directed bench for 8- and 16-bit alu_adder_serial instances,
// checked against an integer-arithmetic reference model.

module tb_alu_adder_serial;
  logic        clk, reset;
  logic [15:0] a, b;
  logic        subtract, carry_in;

  logic        sv8, sr8, rv8, rr8, co8, z8, ov8;
  logic [7:0]  res8;
  logic        sv16, sr16, rv16, rr16, co16, z16, ov16;
  logic [15:0] res16;

  int vectors = 0;
  int errs    = 0;
  bit use16   = 0;

  logic        sel_sr, sel_rv, sel_co, sel_z, sel_ov;
  logic [15:0] sel_res;
  assign sel_sr  = use16 ? sr16  : sr8;
  assign sel_rv  = use16 ? rv16  : rv8;
  assign sel_co  = use16 ? co16  : co8;
  assign sel_z   = use16 ? z16   : z8;
  assign sel_ov  = use16 ? ov16  : ov8;
  assign sel_res = use16 ? res16 : {8'h00, res8};

  alu_adder_serial #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start_valid(sv8), .start_ready(sr8),
    .a(a[7:0]), .b(b[7:0]), .subtract(subtract), .carry_in(carry_in),
    .result_valid(rv8), .result_ready(rr8), .result(res8),
    .carry_out(co8), .zero(z8), .overflow(ov8)
  );

  alu_adder_serial #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .start_valid(sv16), .start_ready(sr16),
    .a(a), .b(b), .subtract(subtract), .carry_in(carry_in),
    .result_valid(rv16), .result_ready(rr16), .result(res16),
    .carry_out(co16), .zero(z16), .overflow(ov16)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer add/subtract, signed range test for overflow.
  task automatic model(input bit w, input logic [15:0] ia, ib, input bit isub, icin,
                       output longint res, output longint co, output longint z,
                       output longint ov);
    longint ua, ub, sa, sb, tot, s, mask, smax, smin;
    int wd;
    wd   = w ? 16 : 8;
    mask = (longint'(1) << wd) - 1;
    ua   = longint'(ia) & mask;
    ub   = longint'(ib) & mask;
    sa   = (ua >= (longint'(1) << (wd-1))) ? ua - (mask + 1) : ua;
    sb   = (ub >= (longint'(1) << (wd-1))) ? ub - (mask + 1) : ub;
    smax = (longint'(1) << (wd-1)) - 1;
    smin = -(longint'(1) << (wd-1));
    if (!isub) begin
      tot = ua + ub + longint'(icin);
      co  = (tot > mask) ? 1 : 0;
      s   = sa + sb + longint'(icin);
    end else begin
      tot = ua - ub - longint'(icin);
      co  = (tot < 0) ? 1 : 0;
      s   = sa - sb - longint'(icin);
    end
    res = tot & mask;
    z   = (res == 0) ? 1 : 0;
    ov  = (s > smax || s < smin) ? 1 : 0;
  endtask

  task automatic do_op(input bit w, input logic [15:0] ia, ib, input bit isub, icin,
                       input int stall);
    longint eres, eco, ez, eov;
    int cyc;
    bit got;
    model(w, ia, ib, isub, icin, eres, eco, ez, eov);
    use16 = w;
    @(negedge clk);
    chk("start_ready_idle", sel_sr, 1);
    a = ia; b = ib; subtract = isub; carry_in = icin;
    if (w) sv16 = 1; else sv8 = 1;
    @(posedge clk);
    #1;
    sv8 = 0; sv16 = 0;
    a = 16'($urandom); b = 16'($urandom);
    subtract = 1'($urandom); carry_in = 1'($urandom);
    cyc = 0; got = 0;
    while (cyc < 20 && !got) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (sel_rv) got = 1;
      else chk("start_ready_busy", sel_sr, 0);
    end
    chk("latency", cyc, w ? 4 : 2);
    if (!got) return;
    chk("result", sel_res, eres);
    chk("carry_out", sel_co, eco);
    chk("zero", sel_z, ez);
    chk("overflow", sel_ov, eov);
    for (int i = 0; i < stall; i++) begin
      if (w) sv16 = ~sv16; else sv8 = ~sv8;
      a = 16'($urandom); b = 16'($urandom);
      @(negedge clk);
      chk("hold_valid", sel_rv, 1);
      chk("hold_ready", sel_sr, 0);
      chk("hold_result", sel_res, eres);
    end
    sv8 = 0; sv16 = 0;
    if (w) rr16 = 1; else rr8 = 1;
    @(posedge clk);
    #1;
    rr8 = 0; rr16 = 0;
    @(negedge clk);
    chk("consumed_valid", sel_rv, 0);
    chk("consumed_ready", sel_sr, 1);
    chk("idle_result_held", sel_res, eres);
  endtask

  initial begin
    reset = 1; a = 0; b = 0; subtract = 0; carry_in = 0;
    sv8 = 0; sv16 = 0; rr8 = 0; rr16 = 0;
    #1;
    chk("rst_valid8", rv8, 0);
    chk("rst_result8", res8, 0);
    chk("rst_flags8", {co8, z8, ov8}, 0);
    chk("rst_valid16", rv16, 0);
    chk("rst_result16", res16, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 0;
    #1;
    chk("rst_ready8", sr8, 1);
    chk("rst_ready16", sr16, 1);

    // Directed cases for 8-bit
    do_op(0, 16'h3C, 16'h47, 0, 0, 0);
    do_op(0, 16'hFF, 16'h01, 0, 0, 1);
    do_op(0, 16'h7F, 16'h00, 0, 1, 0);
    do_op(0, 16'h10, 16'h01, 1, 0, 0);
    do_op(0, 16'h00, 16'h01, 1, 0, 0);
    do_op(0, 16'h80, 16'h01, 1, 0, 0);
    do_op(0, 16'h05, 16'h04, 1, 1, 5);
    do_op(0, 16'h3C, 16'h47, 0, 0, 0);

    // Reset in the middle of RUN, after the first nibble
    use16 = 0;
    @(negedge clk);
    a = 16'h3C; b = 16'h47; subtract = 0; carry_in = 0; sv8 = 1;
    @(posedge clk);
    #1 sv8 = 0;
    @(posedge clk);
    #2 reset = 1;
    #1;
    chk("midrun_valid", rv8, 0);
    chk("midrun_result", res8, 0);
    chk("midrun_flags", {co8, z8, ov8}, 0);
    chk("midrun_ready", sr8, 1);
    @(negedge clk);
    reset = 0;
    do_op(0, 16'h01, 16'h01, 0, 0, 0);

    // Directed 16-bit
    do_op(1, 16'h0FFF, 16'h0001, 0, 0, 0);
    do_op(1, 16'h8000, 16'h0001, 1, 0, 2);

    // Random mix over both widths
    for (int i = 0; i < 40; i++)
      do_op(1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
            int'($urandom_range(0, 3)));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
